mem_controller: RTL and testbench

- Handshaked memory controller between the processor's MAR/MDR datapath and a word-addressed on-chip RAM.
- Replaces the raw mode/address/data coupling with a request/response protocol.
- Inserts a programmable number of wait states per access.
- Holds a response until the processor consumes it, so multi-cycle control sequences stall cleanly on memory.

---
 rtl/mem_controller_pkg.sv | 18 +
 rtl/mem_controller_mem_array.sv | 25 ++
 rtl/mem_controller.sv | 149 ++++++++++++++
 tb/tb_mem_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_controller_pkg.sv
// Shared constants for mem_controller: FSM state encodings and request direction codes.
package mem_controller_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    MC_IDLE   = 2'd0,
    MC_WAIT   = 2'd1,
    MC_ACCESS = 2'd2,
    MC_RESP   = 2'd3
  } mc_state_t;

  typedef enum logic {
    MemReqR = 1'b0,
    MemReqW = 1'b1
  } mem_req_t;

endpackage

// File: rtl/mem_controller_mem_array.sv
// Synchronous single-port RAM, read-first, read data registered one cycle; contents are never reset.
module mem_controller_mem_array #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_controller.sv
// Handshaked request/response controller in front of a word-addressed RAM with programmable wait states.
// Optional bounds checking of the full request address is enabled by defining MEM_BOUNDS_CHECK_EN.
module mem_controller
  import mem_controller_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [WIDTH-1:0]  i_req_wdata,
  output logic              o_req_ready,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [WIDTH-1:0]  o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mc_state_t        r_state;
  mc_state_t        w_next_state;
  logic [3:0]       r_wait_cnt;
  mem_req_t         r_dir;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_wdata;
  logic             r_oob;
  logic [WIDTH-1:0] r_rsp_rdata;
  logic             r_rsp_err;

  logic             w_req_oob;
  logic             w_ram_we;
  logic [IDX_W-1:0] w_ram_addr;
  logic [WIDTH-1:0] w_ram_rdata;

`ifdef MEM_BOUNDS_CHECK_EN
  assign w_req_oob = (i_req_addr >= ADDR_W'(DEPTH));
`else
  logic w_unused_addr_hi;
  assign w_req_oob        = 1'b0;
  assign w_unused_addr_hi = ^i_req_addr[ADDR_W-1:IDX_W];
`endif

  // The RAM is addressed from the live request while idle so its registered read
  // is already settled by the time ACCESS completes, even with zero wait states.
  assign w_ram_addr = (r_state == MC_IDLE) ? i_req_addr[IDX_W-1:0] : r_idx;

  mem_controller_mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem_array (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= MC_IDLE;
      r_wait_cnt  <= '0;
      r_dir       <= MemReqR;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_oob       <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        MC_IDLE: begin
          if (i_req_valid) begin
            r_dir      <= mem_req_t'(i_req_write);
            r_idx      <= i_req_addr[IDX_W-1:0];
            r_wdata    <= i_req_wdata;
            r_oob      <= w_req_oob;
            r_wait_cnt <= WAIT_LOAD;
          end
        end
        MC_WAIT: begin
          if (r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        MC_ACCESS: begin
          r_rsp_err <= r_oob;
          if (r_oob) begin
            r_rsp_rdata <= '0;
          end else if (r_dir == MemReqW) begin
            r_rsp_rdata <= r_wdata;
          end else begin
            r_rsp_rdata <= w_ram_rdata;
          end
        end
        MC_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_req_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    o_busy       = 1'b1;
    w_ram_we     = 1'b0;
    case (r_state)
      MC_IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_req_valid) begin
          w_next_state = (WAIT_CYCLES == 0) ? MC_ACCESS : MC_WAIT;
        end
      end
      MC_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_next_state = MC_ACCESS;
        end
      end
      MC_ACCESS: begin
        w_ram_we     = (r_dir == MemReqW) && !r_oob;
        w_next_state = MC_RESP;
      end
      MC_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_next_state = MC_IDLE;
        end
      end
      default: w_next_state = MC_IDLE;
    endcase
  end

  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: a WAIT_CYCLES=2 instance driven through a request queue and a WAIT_CYCLES=0 instance for latency.
module tb_mem_controller;

  localparam int W = 2;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          accept;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;

  logic        z_req_valid = 1'b0, z_req_write = 1'b0, z_rsp_ready = 1'b1;
  logic [15:0] z_req_addr = '0, z_req_wdata = '0;
  logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
  logic [15:0] z_rsp_rdata;

  int   n_cmp = 0, n_bad = 0, cyc = 0, last_hs = -1;
  exp_t exp_q[$];
  logic seen = 1'b0;
  logic [15:0] held;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_controller #(.WIDTH(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(W)) dut (
    .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_req_ready(req_ready),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err), .o_busy(busy));

  mem_controller #(.WIDTH(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_req_valid(z_req_valid), .i_req_write(z_req_write),
    .i_req_addr(z_req_addr), .i_req_wdata(z_req_wdata), .o_req_ready(z_req_ready),
    .o_rsp_valid(z_rsp_valid), .i_rsp_ready(z_rsp_ready), .o_rsp_rdata(z_rsp_rdata),
    .o_rsp_err(z_rsp_err), .o_busy(z_busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops on the first cycle of each response, then checks it holds until consumed.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (reset) begin
      seen = 1'b0;
    end else if (rsp_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_latency", 32'(cyc - e.accept), 32'(W + 1));
          $display("rsp: rdata=0x%04h err=%0d accepted@%0d valid@%0d", rsp_rdata, rsp_err, e.accept, cyc);
        end
        seen = 1'b1;
        held = rsp_rdata;
      end else begin
        chk("rsp_stable", 32'(rsp_rdata), 32'(held));
      end
      if (rsp_ready) begin
        last_hs = cyc + 1;
        seen = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rd, input logic exp_err, input bit push,
                        output int acc);
    exp_t e;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    acc = -1;
    for (int k = 0; k < 60; k++) begin
      if (req_ready) begin
        acc = cyc + 1;
        if (push) begin
          e.rdata = exp_rd; e.err = exp_err; e.accept = acc;
          exp_q.push_back(e);
        end
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) chk("accept_timeout", 32'd1, 32'd0);
    $display("req: %s addr=0x%04h wdata=0x%04h accepted@%0d", wr ? "W" : "R", addr, wdata, acc);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 16'hDEAD; req_wdata = 16'hDEAD; req_write = ~wr;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100; k++) begin
      if (exp_q.size() == 0 && !busy && !rsp_valid) break;
      @(negedge clk);
    end
    if (k == 100) chk("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Write 0xBEEF to 5: ready drops, busy high through the wait states.
    do_req(1'b1, 16'h0005, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1, a1);
    chk("ready_after_accept", 32'(req_ready), 32'd0);
    chk("busy_wait", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_wait2", 32'(busy), 32'd1);
    wait_idle();

    do_req(1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 1'b1, a1);
    wait_idle();

    // Stall the response for 5 cycles; a held request is accepted one cycle after the handshake.
    rsp_ready = 1'b0;
    do_req(1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 1'b1, a1);
    fork
      begin
        do_req(1'b1, 16'h0020, 16'hCAFE, 16'hCAFE, 1'b0, 1'b1, a2);
        chk("accept_after_rsp", 32'(a2), 32'(last_hs + 1));
      end
      begin
        for (int k = 0; k < 60 && !rsp_valid; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        rsp_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset during WAIT abandons the pending write.
    do_req(1'b1, 16'h0010, 16'h5555, 16'h5555, 1'b0, 1'b1, a1);
    wait_idle();
    do_req(1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0, 1'b0, a1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_req(1'b0, 16'h0010, 16'h0000, 16'h5555, 1'b0, 1'b1, a1);
    wait_idle();

`ifdef MEM_BOUNDS_CHECK_EN
    do_req(1'b1, 16'h0003, 16'h7777, 16'h7777, 1'b0, 1'b1, a1);
    wait_idle();
    do_req(1'b1, 16'h0403, 16'h00AA, 16'h0000, 1'b1, 1'b1, a1);
    wait_idle();
    chk("err_cleared", 32'(rsp_err), 32'd0);
    do_req(1'b0, 16'h0003, 16'h0000, 16'h7777, 1'b0, 1'b1, a1);
    wait_idle();
`else
    do_req(1'b1, 16'h0403, 16'h00AA, 16'h00AA, 1'b0, 1'b1, a1);
    wait_idle();
    do_req(1'b0, 16'h0003, 16'h0000, 16'h00AA, 1'b0, 1'b1, a1);
    wait_idle();
`endif

    // Back-to-back reads: accepts spaced WAIT_CYCLES+3 apart.
    do_req(1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 1'b1, a1);
    do_req(1'b0, 16'h0020, 16'h0000, 16'hCAFE, 1'b0, 1'b1, a2);
    chk("b2b_spacing", 32'(a2 - a1), 32'(W + 3));
    wait_idle();

    // Zero-wait instance: response one edge after accept.
    for (int i = 0; i < 2; i++) begin
      z_req_valid = 1'b1; z_req_write = (i == 0); z_req_addr = 16'h0005; z_req_wdata = 16'hBEEF;
      chk("z0_ready", 32'(z_req_ready), 32'd1);
      @(negedge clk);
      z_req_valid = 1'b0; z_req_addr = 16'hDEAD; z_req_wdata = 16'h0000;
      chk("z0_valid_early", 32'(z_rsp_valid), 32'd0);
      @(negedge clk);
      chk("z0_valid", 32'(z_rsp_valid), 32'd1);
      chk("z0_rdata", 32'(z_rsp_rdata), 32'hBEEF);
      chk("z0_err", 32'(z_rsp_err), 32'd0);
      $display("z0 %s: valid=%0d rdata=0x%04h", (i == 0) ? "W" : "R", z_rsp_valid, z_rsp_rdata);
      @(negedge clk);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
